led_seq_gen: RTL and testbench

//  Parametrised LED pattern sequencer. Runtime-loadable clock-enable divider

---
 rtl/led_seq_pkg.sv | 17 +
 rtl/clk_en_div.sv | 51 +++++
 rtl/led_seq_gen.sv | 89 ++++++++
 tb/tb_led_seq_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared mode encodings and the Gray-code helper for the LED sequencer.
// Latency: n/a (declarations only). Backpressure: n/a.
package led_seq_pkg;

    localparam logic [1:0] MODE_UP      = 2'b00;
    localparam logic [1:0] MODE_DOWN    = 2'b01;
    localparam logic [1:0] MODE_GRAY    = 2'b10;
    localparam logic [1:0] MODE_JOHNSON = 2'b11;

    // Widest pattern the helper supports; callers truncate to their own width.
    localparam int GRAY_MAX_W = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/clk_en_div.sv
// Runtime-loadable clock-enable divider: one-cycle tick every div_q+1 clocks.
// Latency: tick registered, high the cycle after cnt reaches div_q. Backpressure: none.
module clk_en_div #(
    parameter int          DIV_W       = 32,
    parameter int unsigned DIV_DEFAULT = 250000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_value,
    output logic             tick
);

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_DEFAULT);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;

    // A load restarts the count so the new period is exact from the load edge.
    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        tick_d = 1'b0;
        if (div_load) begin
            div_d = div_value;
            cnt_d = '0;
        end else if (cnt_q == div_q) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            div_q  <= DIV_RST;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/led_seq_gen.sv
// LED pattern sequencer: binary up/down, Gray and Johnson patterns stepped by a divided tick.
// Latency: state/wrap update at the edge where tick(&en) or step is seen. Backpressure: none.
module led_seq_gen
    import led_seq_pkg::*;
#(
    parameter int          W           = 3,
    parameter int          DIV_W       = 32,
    parameter int unsigned DIV_DEFAULT = 250000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             step,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_value,
    output logic [W-1:0]     state,
    output logic [W-1:0]     led,
    output logic             tick,
    output logic             wrap
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] seq_q, seq_d;
    logic [W-1:0] state_q, state_d;
    logic [1:0]   mode_q, mode_d;
    logic         wrap_q, wrap_d;
    logic         adv;

    clk_en_div #(
        .DIV_W       (DIV_W),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .div_load  (div_load),
        .div_value (div_value),
        .tick      (tick)
    );

    // A mode change restarts the pattern at zero and swallows any advance that cycle.
    always_comb begin
        adv    = (en & tick) | step;
        mode_d = mode_q;
        seq_d  = seq_q;
        wrap_d = 1'b0;
        if (mode != mode_q) begin
            mode_d = mode;
            seq_d  = '0;
        end else if (adv) begin
            case (mode_q)
                MODE_UP, MODE_GRAY: begin
                    seq_d  = seq_q + ONE;
                    wrap_d = &seq_q;
                end
                MODE_DOWN: begin
                    seq_d  = seq_q - ONE;
                    wrap_d = ~|seq_q;
                end
                default: begin
                    seq_d  = {seq_q[W-2:0], ~seq_q[W-1]};
                    wrap_d = (seq_d == '0);
                end
            endcase
        end
        // Output register takes the next pattern so state never lags seq.
        state_d = (mode_d == MODE_GRAY) ? W'(bin2gray(32'(seq_d))) : seq_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q   <= '0;
            state_q <= '0;
            mode_q  <= MODE_UP;
            wrap_q  <= 1'b0;
        end else begin
            seq_q   <= seq_d;
            state_q <= state_d;
            mode_q  <= mode_d;
            wrap_q  <= wrap_d;
        end
    end

    assign state = state_q;
    assign led   = state_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_led_seq_gen.sv
// Directed bench for led_seq_gen with W=3, DIV_W=8, DIV_DEFAULT=3 (tick every 4 clocks).
module tb_led_seq_gen;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       step;
    logic       div_load;
    logic [7:0] div_value;
    logic [2:0] state;
    logic [2:0] led;
    logic       tick;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    led_seq_gen #(
        .W           (3),
        .DIV_W       (8),
        .DIV_DEFAULT (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .step      (step),
        .div_load  (div_load),
        .div_value (div_value),
        .state     (state),
        .led       (led),
        .tick      (tick),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1);
    end

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] mode;
        logic       step;
        logic       dl;
        logic [7:0] dv;
        logic [2:0] st;
        logic       tk;
        logic       wr;
    } vec_t;

    vec_t vecs [15];

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [2:0] es, input logic et, input logic ew);
        chk({nm, " state"}, 32'(state), 32'(es));
        chk({nm, " led"},   32'(led),   32'(es));
        chk({nm, " tick"},  32'(tick),  32'(et));
        chk({nm, " wrap"},  32'(wrap),  32'(ew));
    endtask

    // Wait (bounded) for the next tick, then check the pattern after the advance edge.
    task automatic adv_chk(input string nm, input logic [2:0] es, input logic ew);
        int n;
        n = 0;
        while (tick !== 1'b1 && n < 12) begin
            clk_step();
            n++;
        end
        if (tick !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s tick timeout: got %b required 1", nm, tick);
        end
        clk_step();
        chk_out(nm, es, 1'b0, ew);
    endtask

    logic [2:0] gray_exp [8];
    logic [2:0] john_exp [6];
    logic [2:0] exp_st;

    initial begin
        // rst en mode step dl dv | state tick wrap
        vecs[0]  = '{1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 8'd0, 3'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 8'd0, 3'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 8'd0, 3'd7, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 8'd0, 3'd7, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 8'd0, 3'd6, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 8'd0, 3'd6, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 8'd0, 3'd5, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 8'd0, 3'd5, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 8'd0, 3'd5, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 8'd0, 3'd4, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 8'd0, 3'd4, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 8'd0, 3'd4, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 8'd0, 3'd4, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 8'd0, 3'd0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 8'd0, 3'd1, 1'b0, 1'b0};

        gray_exp = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        john_exp = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000};

        rst       = 1'b1;
        en        = 1'b1;
        mode      = 2'b00;
        step      = 1'b0;
        div_load  = 1'b0;
        div_value = 8'd0;

        // Reset state, then binary up with tick every 4 clocks
        clk_step();
        chk_out("reset", 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int k = 1; k <= 36; k++) begin
            clk_step();
            exp_st = (k >= 5) ? 3'((k - 1) / 4) : 3'd0;
            chk_out($sformatf("up k=%0d", k), exp_st, (k % 4) == 0, k == 33);
        end

        // Gray up; switch lands on a tick cycle, which must be swallowed
        mode = 2'b10;
        clk_step();
        chk_out("gray switch", 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            adv_chk($sformatf("gray %0d", i), gray_exp[i], i == 7);

        // Johnson, period 6
        mode = 2'b11;
        clk_step();
        chk_out("john switch", 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            adv_chk($sformatf("john %0d", i), john_exp[i], i == 5);

        // Step pulses, en gating, step+tick, down->up switch
        for (int i = 0; i < 15; i++) begin
            rst       = vecs[i].rst;
            en        = vecs[i].en;
            mode      = vecs[i].mode;
            step      = vecs[i].step;
            div_load  = vecs[i].dl;
            div_value = vecs[i].dv;
            clk_step();
            chk_out($sformatf("vec %0d", i), vecs[i].st, vecs[i].tk, vecs[i].wr);
        end
        step = 1'b0;

        // div_load of 0: quiet load cycle, then tick and advance every cycle
        div_load  = 1'b1;
        div_value = 8'd0;
        clk_step();
        chk_out("load0", 3'd1, 1'b0, 1'b0);
        div_load = 1'b0;
        clk_step();
        chk_out("load0 first tick", 3'd1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            clk_step();
            chk_out($sformatf("fast %0d", i), 3'(i + 2), 1'b1, i == 6);
        end

        // div_load coincident with tick still advances; reset restores default divider
        div_load  = 1'b1;
        div_value = 8'd10;
        clk_step();
        chk_out("load10 adv", 3'd1, 1'b0, 1'b0);
        div_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clk_step();
            chk_out($sformatf("slow hold %0d", i), 3'd1, 1'b0, 1'b0);
        end
        rst = 1'b1;
        clk_step();
        chk_out("mid reset", 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            clk_step();
            exp_st = (k >= 9) ? 3'd2 : ((k >= 5) ? 3'd1 : 3'd0);
            chk_out($sformatf("post rst k=%0d", k), exp_st, (k == 4) || (k == 8), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
